// File: rtl/collision_sequencer.sv
// Collision sequencer: one shared map-probe / box-compare engine serving the player and
// N_ENEMIES enemies. done arrives a fixed 5*N_ENEMIES+5 cycles after the start edge.
module collision_sequencer #(
    parameter int unsigned N_ENEMIES    = 3,
    parameter int unsigned SPRITE_W     = 16,
    parameter int unsigned SPRITE_H     = 16,
    parameter int unsigned ATTACK_REACH = 8,
    parameter int unsigned MAP_W        = 320,
    parameter int unsigned MAP_H        = 240
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     init,
    input  logic                     collision_enable,
    input  logic [8:0]               char_x,
    input  logic [7:0]               char_y,
    input  logic [2:0]               direction_char,
    input  logic [2:0]               facing_char,
    input  logic                     attack,
    input  logic [9*N_ENEMIES-1:0]   enemy_x,
    input  logic [8*N_ENEMIES-1:0]   enemy_y,
    input  logic [3*N_ENEMIES-1:0]   direction_enemy,
    input  logic [N_ENEMIES-1:0]     enemy_alive,
    output logic [12:0]              map_addr,
    input  logic                     map_data,
    output logic                     c_map_collision,
    output logic [N_ENEMIES-1:0]     e_map_collision,
    output logic [N_ENEMIES-1:0]     c_e_collision,
    output logic [N_ENEMIES-1:0]     e_hit,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned IW = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
    localparam logic signed [12:0] SW  = 13'(SPRITE_W);
    localparam logic signed [12:0] SH  = 13'(SPRITE_H);
    localparam logic signed [12:0] RCH = 13'(ATTACK_REACH);
    localparam logic signed [12:0] MW  = 13'(MAP_W);
    localparam logic signed [12:0] MH  = 13'(MAP_H);

    typedef enum logic [2:0] {StIdle, StCharMap, StEnemyMap, StEnemyBox, StDone} state_t;

    state_t                 state_q;
    logic [1:0]             step_q;
    logic [IW-1:0]          idx_q;
    logic [8:0]             cx_q;
    logic [7:0]             cy_q;
    logic [2:0]             cdir_q, cface_q;
    logic                   attack_q;
    logic [9*N_ENEMIES-1:0] ex_q;
    logic [8*N_ENEMIES-1:0] ey_q;
    logic [3*N_ENEMIES-1:0] edir_q;
    logic [N_ENEMIES-1:0]   alive_q;
    logic                   cmap_s_q;
    logic [N_ENEMIES-1:0]   emap_s_q, ce_s_q, hit_s_q;

    function automatic logic dir_ok(input logic [2:0] d);
        return (d >= 3'd1) && (d <= 3'd4);
    endfunction

    logic [8:0]         sel_x;
    logic [7:0]         sel_y;
    logic [2:0]         sel_dir;
    logic signed [12:0] px, py, cxs, cys, exs, eys, dx, dy, sx0, sx1, sy0, sy1;
    logic               oob, blk, ce_now, hit_now;

    always_comb begin
        if (state_q == StCharMap) begin
            sel_x   = cx_q;
            sel_y   = cy_q;
            sel_dir = cdir_q;
        end else begin
            sel_x   = ex_q[9*idx_q +: 9];
            sel_y   = ey_q[8*idx_q +: 8];
            sel_dir = edir_q[3*idx_q +: 3];
        end
    end

    // step_q[1] selects the second leading-edge corner
    always_comb begin
        px = $signed({4'b0, sel_x});
        py = $signed({5'b0, sel_y});
        case (sel_dir)
            3'd1: begin py = py - 13'sd1; if (step_q[1]) px = px + SW - 13'sd1; end
            3'd2: begin py = py + SH;     if (step_q[1]) px = px + SW - 13'sd1; end
            3'd3: begin px = px - 13'sd1; if (step_q[1]) py = py + SH - 13'sd1; end
            3'd4: begin px = px + SW;     if (step_q[1]) py = py + SH - 13'sd1; end
            default: ;
        endcase
        oob = (px < 0) || (px >= MW) || (py < 0) || (py >= MH);
        blk = oob || map_data;
    end

    assign map_addr = ((state_q == StCharMap || state_q == StEnemyMap) && !oob)
                      ? {py[7:2], px[8:2]} : 13'd0;

    always_comb begin
        cxs = $signed({4'b0, cx_q});
        cys = $signed({5'b0, cy_q});
        exs = $signed({4'b0, sel_x});
        eys = $signed({5'b0, sel_y});
        dx  = cxs - exs;
        dy  = cys - eys;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        ce_now = (dx < SW) && (dy < SH);
        sx0 = cxs;
        sx1 = cxs + SW;
        sy0 = cys;
        sy1 = cys + SH;
        case (cface_q)
            3'd1: begin sy0 = cys - RCH; sy1 = cys;            end
            3'd2: begin sy0 = cys + SH;  sy1 = cys + SH + RCH; end
            3'd3: begin sx0 = cxs - RCH; sx1 = cxs;            end
            3'd4: begin sx0 = cxs + SW;  sx1 = cxs + SW + RCH; end
            default: ;
        endcase
        hit_now = attack_q && dir_ok(cface_q) && (sx0 < exs + SW) && (exs < sx1)
                  && (sy0 < eys + SH) && (eys < sy1);
    end

    always_ff @(posedge clock) begin
        if (reset || init) begin
            state_q         <= StIdle;
            step_q          <= 2'd0;
            idx_q           <= '0;
            cx_q            <= '0;
            cy_q            <= '0;
            cdir_q          <= '0;
            cface_q         <= '0;
            attack_q        <= 1'b0;
            ex_q            <= '0;
            ey_q            <= '0;
            edir_q          <= '0;
            alive_q         <= '0;
            cmap_s_q        <= 1'b0;
            emap_s_q        <= '0;
            ce_s_q          <= '0;
            hit_s_q         <= '0;
            c_map_collision <= 1'b0;
            e_map_collision <= '0;
            c_e_collision   <= '0;
            e_hit           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (collision_enable) begin
                        cx_q     <= char_x;
                        cy_q     <= char_y;
                        cdir_q   <= direction_char;
                        cface_q  <= facing_char;
                        attack_q <= attack;
                        ex_q     <= enemy_x;
                        ey_q     <= enemy_y;
                        edir_q   <= direction_enemy;
                        alive_q  <= enemy_alive;
                        cmap_s_q <= 1'b0;
                        emap_s_q <= '0;
                        ce_s_q   <= '0;
                        hit_s_q  <= '0;
                        step_q   <= 2'd0;
                        idx_q    <= '0;
                        busy     <= 1'b1;
                        state_q  <= StCharMap;
                    end
                end
                StCharMap: begin
                    if (step_q[0] && dir_ok(cdir_q) && blk) cmap_s_q <= 1'b1;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) state_q <= StEnemyMap;
                end
                StEnemyMap: begin
                    if (step_q[0] && alive_q[idx_q] && dir_ok(sel_dir) && blk)
                        emap_s_q[idx_q] <= 1'b1;
                    step_q <= step_q + 2'd1;
                    if (step_q == 2'd3) state_q <= StEnemyBox;
                end
                StEnemyBox: begin
                    ce_s_q[idx_q]  <= alive_q[idx_q] && ce_now;
                    hit_s_q[idx_q] <= alive_q[idx_q] && hit_now;
                    if (idx_q == IW'(N_ENEMIES - 1)) begin
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + IW'(1);
                        state_q <= StEnemyMap;
                    end
                end
                StDone: begin
                    c_map_collision <= cmap_s_q;
                    e_map_collision <= emap_s_q;
                    c_e_collision   <= ce_s_q;
                    e_hit           <= hit_s_q;
                    done            <= 1'b1;
                    busy            <= 1'b0;
                    state_q         <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_sequencer.sv
// Directed bench for collision_sequencer: scoreboard of expected results per scan, checked at
// done, plus latency, busy, abort and N_ENEMIES=5 latency checks.
module tb_collision_sequencer;

    typedef struct packed {
        logic       cmap;
        logic [2:0] emap;
        logic [2:0] ce;
        logic [2:0] hit;
    } res_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        init = 1'b0;
    logic        collision_enable = 1'b0;
    logic [8:0]  char_x;
    logic [7:0]  char_y;
    logic [2:0]  direction_char, facing_char;
    logic        attack;
    logic [26:0] enemy_x;
    logic [23:0] enemy_y;
    logic [8:0]  direction_enemy;
    logic [2:0]  enemy_alive;
    logic [12:0] map_addr;
    logic        map_data = 1'b0;
    logic        c_map_collision;
    logic [2:0]  e_map_collision, c_e_collision, e_hit;
    logic        busy, done;

    logic        en5 = 1'b0;
    logic [12:0] map_addr5;
    logic        cmap5, busy5, done5;
    logic [4:0]  emap5, ce5, hit5;

    logic [12:0] blocked_addr = 13'h1fff;
    logic        oob_read = 1'b0;
    int          errors = 0;
    int          checks = 0;
    res_t        exp_q[$];

    collision_sequencer dut (
        .clock(clock), .reset(reset), .init(init), .collision_enable(collision_enable),
        .char_x(char_x), .char_y(char_y), .direction_char(direction_char),
        .facing_char(facing_char), .attack(attack), .enemy_x(enemy_x), .enemy_y(enemy_y),
        .direction_enemy(direction_enemy), .enemy_alive(enemy_alive), .map_addr(map_addr),
        .map_data(map_data), .c_map_collision(c_map_collision),
        .e_map_collision(e_map_collision), .c_e_collision(c_e_collision), .e_hit(e_hit),
        .busy(busy), .done(done)
    );

    collision_sequencer #(.N_ENEMIES(5)) dut5 (
        .clock(clock), .reset(reset), .init(1'b0), .collision_enable(en5),
        .char_x(9'd0), .char_y(8'd0), .direction_char(3'd0), .facing_char(3'd0),
        .attack(1'b0), .enemy_x(45'd0), .enemy_y(40'd0), .direction_enemy(15'd0),
        .enemy_alive(5'h1f), .map_addr(map_addr5), .map_data(1'b0),
        .c_map_collision(cmap5), .e_map_collision(emap5), .c_e_collision(ce5), .e_hit(hit5),
        .busy(busy5), .done(done5)
    );

    always #5 clock = ~clock;

    // tile map with 1-cycle read latency and a single blocked tile
    always @(posedge clock) map_data <= (map_addr == blocked_addr);

    // wrapped addresses of the x=-1 probes for an enemy at (0,50)
    always @(negedge clock)
        if (map_addr == 13'd1663 || map_addr == 13'd2175) oob_read = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic c, input logic [2:0] em, input logic [2:0] ce,
                                input logic [2:0] h);
        return {c, em, ce, h};
    endfunction

    task automatic set_enemy(input int i, input int x, input int y, input int d);
        enemy_x[9*i +: 9]         = 9'(x);
        enemy_y[8*i +: 8]         = 8'(y);
        direction_enemy[3*i +: 3] = 3'(d);
    endtask

    task automatic defaults();
        char_x = 9'd100; char_y = 8'd100;
        direction_char = 3'd0; facing_char = 3'd0; attack = 1'b0;
        set_enemy(0, 200, 30, 0);
        set_enemy(1, 30, 180, 0);
        set_enemy(2, 250, 150, 0);
        enemy_alive  = 3'b111;
        blocked_addr = 13'h1fff;
    endtask

    // Starts a scan at the current negedge; returns at the negedge where done is seen.
    task automatic run(input string tag, input res_t exp);
        logic [8:0]  s_cx;
        logic [7:0]  s_cy;
        logic [2:0]  s_cd, s_cf, s_al;
        logic        s_at;
        logic [26:0] s_ex;
        logic [23:0] s_ey;
        logic [8:0]  s_ed;
        res_t        e, got;
        int          lat;
        bit          busy_ok;
        exp_q.push_back(exp);
        collision_enable = 1'b1;
        @(posedge clock);
        #1;
        collision_enable = 1'b0;
        s_cx = char_x; s_cy = char_y; s_cd = direction_char; s_cf = facing_char;
        s_at = attack; s_ex = enemy_x; s_ey = enemy_y; s_ed = direction_enemy; s_al = enemy_alive;
        // results must come from the snapshot, not the live inputs
        char_x = ~char_x; char_y = ~char_y; direction_char = ~direction_char;
        facing_char = ~facing_char; attack = ~attack; enemy_x = ~enemy_x;
        enemy_y = ~enemy_y; direction_enemy = ~direction_enemy; enemy_alive = ~enemy_alive;
        lat = 0;
        busy_ok = 1'b1;
        @(negedge clock);
        if (busy !== 1'b1) busy_ok = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        char_x = s_cx; char_y = s_cy; direction_char = s_cd; facing_char = s_cf;
        attack = s_at; enemy_x = s_ex; enemy_y = s_ey; direction_enemy = s_ed; enemy_alive = s_al;
        chk({tag, " latency"}, lat, 20);
        chk({tag, " busy_during"}, 32'(busy_ok), 1);
        chk({tag, " busy_at_done"}, 32'(busy), 0);
        e   = exp_q.pop_front();
        got = {c_map_collision, e_map_collision, c_e_collision, e_hit};
        chk({tag, " c_map"}, 32'(got.cmap), 32'(e.cmap));
        chk({tag, " e_map"}, 32'(got.emap), 32'(e.emap));
        chk({tag, " c_e"}, 32'(got.ce), 32'(e.ce));
        chk({tag, " e_hit"}, 32'(got.hit), 32'(e.hit));
    endtask

    initial begin
        int   ndone, first;
        res_t e, got;
        defaults();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset outputs", {c_map_collision, e_map_collision, c_e_collision, e_hit}, 0);
        chk("reset busy_done", {busy, done}, 0);
        chk("reset map_addr", map_addr, 0);

        run("t1 idle scene", mk(0, 3'b000, 3'b000, 3'b000));

        direction_char = 3'd4; blocked_addr = 13'd3229;
        run("t2 right blocked", mk(1, 3'b000, 3'b000, 3'b000));
        direction_char = 3'd0;
        run("t2 no direction", mk(0, 3'b000, 3'b000, 3'b000));
        direction_char = 3'd1;
        run("t2 up clear", mk(0, 3'b000, 3'b000, 3'b000));
        defaults();

        set_enemy(0, 115, 100, 0);
        run("t3 overlap x", mk(0, 3'b000, 3'b001, 3'b000));
        set_enemy(0, 116, 100, 0);
        run("t3 touch x", mk(0, 3'b000, 3'b000, 3'b000));
        set_enemy(0, 100, 85, 0);
        run("t3 overlap y", mk(0, 3'b000, 3'b001, 3'b000));
        set_enemy(0, 100, 84, 0);
        run("t3 touch y", mk(0, 3'b000, 3'b000, 3'b000));
        defaults();

        facing_char = 3'd4; attack = 1'b1; set_enemy(1, 120, 100, 0);
        run("t4 sword right", mk(0, 3'b000, 3'b000, 3'b010));
        attack = 1'b0;
        run("t4 no attack", mk(0, 3'b000, 3'b000, 3'b000));
        attack = 1'b1; facing_char = 3'd5;
        run("t4 invalid facing", mk(0, 3'b000, 3'b000, 3'b000));
        facing_char = 3'd4; enemy_alive = 3'b101; set_enemy(1, 110, 100, 3);
        run("t4 dead enemy", mk(0, 3'b000, 3'b000, 3'b000));
        enemy_alive = 3'b111; facing_char = 3'd1; set_enemy(1, 110, 100, 0);
        run("t4 up miss", mk(0, 3'b000, 3'b010, 3'b000));
        set_enemy(1, 100, 85, 0);
        run("t4 up hit", mk(0, 3'b000, 3'b010, 3'b010));
        facing_char = 3'd3; set_enemy(1, 76, 100, 0);
        run("t4 left touch", mk(0, 3'b000, 3'b000, 3'b000));
        set_enemy(1, 77, 100, 0);
        run("t4 left hit", mk(0, 3'b000, 3'b000, 3'b010));
        defaults();

        set_enemy(2, 0, 50, 3);
        oob_read = 1'b0;
        run("t5 left edge", mk(0, 3'b100, 3'b000, 3'b000));
        chk("t5 no oob read", 32'(oob_read), 0);
        set_enemy(2, 304, 0, 4);
        run("t5 right edge", mk(0, 3'b100, 3'b000, 3'b000));
        set_enemy(2, 303, 0, 4);
        run("t5 right inside", mk(0, 3'b000, 3'b000, 3'b000));
        set_enemy(2, 250, 224, 2);
        run("t5 bottom edge", mk(0, 3'b100, 3'b000, 3'b000));
        set_enemy(2, 250, 223, 2);
        run("t5 bottom inside", mk(0, 3'b000, 3'b000, 3'b000));
        set_enemy(2, 250, 150, 0);
        set_enemy(0, 200, 30, 2); blocked_addr = 13'd1458;
        run("t5 enemy map", mk(0, 3'b001, 3'b000, 3'b000));
        enemy_alive = 3'b110;
        run("t5 enemy map dead", mk(0, 3'b000, 3'b000, 3'b000));
        defaults();
        set_enemy(2, 250, 0, 1);
        run("t5 top edge", mk(0, 3'b100, 3'b000, 3'b000));

        // abort: outputs from the previous scan must clear with no done
        collision_enable = 1'b1;
        @(posedge clock);
        #1;
        collision_enable = 1'b0;
        @(negedge clock);
        repeat (9) @(negedge clock);
        init = 1'b1;
        @(negedge clock);
        init = 1'b0;
        chk("t6 init clear", {c_map_collision, e_map_collision, c_e_collision, e_hit}, 0);
        chk("t6 init busy", 32'(busy), 0);
        ndone = 0;
        repeat (30) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
        end
        chk("t6 init no done", ndone, 0);

        defaults();
        set_enemy(0, 115, 100, 0);
        exp_q.push_back(mk(0, 3'b000, 3'b001, 3'b000));
        collision_enable = 1'b1;
        @(posedge clock);
        #1;
        collision_enable = 1'b0;
        @(negedge clock);
        ndone = 0;
        first = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (k == 5) collision_enable = 1'b1;
            if (k == 6) collision_enable = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) first = k;
            end
        end
        chk("t6 busy enable ignored", ndone, 1);
        chk("t6 busy latency", first, 20);
        e   = exp_q.pop_front();
        got = {c_map_collision, e_map_collision, c_e_collision, e_hit};
        chk("t6 busy results", 32'(got), 32'(e));

        en5 = 1'b1;
        @(posedge clock);
        #1;
        en5 = 1'b0;
        @(negedge clock);
        ndone = 0;
        first = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clock);
            if (done5 === 1'b1) begin
                ndone++;
                if (first == 0) first = k;
            end
        end
        chk("n5 done count", ndone, 1);
        chk("n5 latency", first, 30);
        chk("n5 c_e", 32'(ce5), 32'h1f);
        chk("n5 others", {cmap5, emap5, hit5, busy5}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/collision_sequencer.md
Name: collision_sequencer

Overview:
- Parametrised successor to the fixed three-enemy collision detector.
- Time-multiplexes a single map-probe and box-compare engine across N_ENEMIES enemies. Reads the tile map through a 1-cycle-latency read port.
- Adds per-enemy alive masking, off-screen blocking and a fixed-latency busy/done handshake.
- Sits between the game control FSM and the character/enemy movement logic.

Parameters:
N_ENEMIES, 3, number of enemy channels (1..8)
SPRITE_W, 16, sprite width in pixels
SPRITE_H, 16, sprite height in pixels
ATTACK_REACH, 8, sword box depth in pixels beyond the facing edge
MAP_W, 320, playfield width in pixels
MAP_H, 240, playfield height in pixels

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
init  in  1  synchronous clear of results; aborts any scan
collision_enable  in  1  start pulse; accepted only in IDLE
char_x  in  9  player x (top-left)
char_y  in  8  player y (top-left)
direction_char  in  3  player motion: 0 none, 1 up, 2 down, 3 left, 4 right, others treated as none
facing_char  in  3  player facing, same encoding
attack  in  1  player attacking
enemy_x  in  9*N_ENEMIES  packed enemy x; enemy i at [9i+8:9i]
enemy_y  in  8*N_ENEMIES  packed enemy y
direction_enemy  in  3*N_ENEMIES  packed enemy motion
enemy_alive  in  N_ENEMIES  1 = enemy active
map_addr  out  13  tile address {py[7:2], px[8:2]}
map_data  in  1  tile blocked; valid the cycle after map_addr
c_map_collision  out  1  player next step blocked
e_map_collision  out  N_ENEMIES  enemy i next step blocked
c_e_collision  out  N_ENEMIES  player box overlaps enemy i
e_hit  out  N_ENEMIES  sword box overlaps enemy i while attacking
busy  out  1  scan in progress
done  out  1  one-cycle pulse; results valid

Behaviour:
- Reset: all outputs 0, map_addr 0, FSM in IDLE. Reset has priority over init. init has the same effect as reset on outputs and FSM.
- FSM states: IDLE -> CHAR_MAP -> ENEMY_MAP(i) -> ENEMY_BOX(i) -> (next i, or DONE) -> IDLE.
- IDLE to CHAR_MAP:
  - Occurs on a clock edge where collision_enable = 1.
  - All position, direction, facing, attack and alive inputs are snapshotted on that edge.
  - busy goes 1 on the same edge.
  - collision_enable is ignored while busy.
- Probes:
  - Each probe takes 2 cycles: issue map_addr, then sample map_data.
  - Each map phase issues 2 probes (4 cycles), i.e. the two leading-edge corners one pixel ahead:
    - up: (x, y-1) and (x+W-1, y-1)
    - down: (x, y+H) and (x+W-1, y+H)
    - left: (x-1, y) and (x-1, y+H-1)
    - right: (x+W, y) and (x+W, y+H-1)
  - Map collision = OR of both samples.
  - Probe coordinates are computed in signed 10/11-bit arithmetic. A probe with x<0, x>=MAP_W, y<0 or y>=MAP_H counts as blocked with no map read; it still takes 2 cycles.
  - Direction none or invalid: probes still occupy their cycles; result forced 0.
- ENEMY_BOX(i) takes 1 cycle:
  - c_e = |cx-ex| < SPRITE_W AND |cy-ey| < SPRITE_H. Strict; edge-touching is not a collision.
  - Sword box is SPRITE_W or SPRITE_H across, ATTACK_REACH deep, adjacent to the facing edge:
    - up: y in [cy-REACH, cy)
    - down: y in [cy+H, cy+H+REACH)
    - left/right: analogous in x
  - e_hit = attack AND (facing valid) AND (sword box overlaps enemy box, half-open intervals).
- Enemies with alive = 0 (snapshot):
  - Consume full cycles.
  - All three results are forced 0.
- Result timing:
  - Results accumulate in shadow registers.
  - All outputs update together on the DONE edge.
  - done = 1 for exactly that cycle; busy returns to 0 on the same edge.
  - Outputs hold until the next done, reset or init.
- Latency: done asserts exactly 5*N_ENEMIES+5 cycles after the accepting edge (20 for N=3). This is independent of data.
- A new collision_enable on the cycle after done starts a new scan.
- init or reset mid-scan:
  - Abort to IDLE.
  - Outputs cleared.
  - No done pulse.

Test Plan:
1. Reset, then pulse collision_enable with all enemies alive and non-overlapping, all map_data 0 -> done pulse exactly 20 cycles later (N=3); all collision outputs 0; busy high for cycles 1..19 and low on the done edge.
2. Char (100,100) moving right; map model returns 1 for tile {25,29} (addr from px=116, py=100) -> c_map_collision=1; the same scan with direction 0 -> 0.
3. Enemy1 at (115,100) vs char (100,100) -> c_e_collision=3'b001. Enemy1 at (116,100) -> 3'b000 (touching edge).
4. Char (100,100) facing right with attack=1, enemy2 at (120,100) -> e_hit=3'b010. Same with attack=0 -> 0. Same with enemy_alive[1]=0 -> all enemy2 outputs 0.
5. Enemy3 at (0,50) moving left -> e_map_collision[2]=1 with no map_addr read for the x=-1 probes. Enemy at (304,0) moving right -> blocked (x=320).
6. Assert init at cycle 10 of a scan -> no done; outputs 0. Pulse collision_enable while busy -> ignored, so a single done follows. N_ENEMIES=5 build -> done latency 30.
